muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide execution unit. Consumes the RegisterFile read operands (rs1_data/rs2_data) and
//   produces a write-back value plus a one-cycle write enable, muxed into RegisterFile rd_data/RegWEn.
//   The core holds PC while busy=1. One operation in flight; radix-2, one bit per cycle.
// PARAMETERS
//   XLEN      32   operand/result width; only 32 supported (iteration counter is $clog2(XLEN)+1 bits)
// PORTS
//   clk       in   1     single clock; all state updates on posedge clk
//   rst       in   1     reset is synchronous and active-high
//   start     in   1     request; sampled only in IDLE
//   funct3    in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   op_a      in   32    rs1_data (multiplicand / dividend)
//   op_b      in   32    rs2_data (multiplier / divisor)
//   rd_in     in   5     destination register captured with start
//   busy      out  1     1 from the edge accepting start until the edge leaving DONE; core stall
//   done      out  1     one-cycle pulse, result valid
//   rd_we     out  1     equals done; drives RegWEn (RegisterFile discards x0 writes)
//   rd_out    out  5     captured rd_in, stable while busy and held after done
//   result    out  32    write-back value, held until the next accepted start
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, rd_we=0, rd_out=0, result=0, all internal regs cleared.
//   States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start=1 latches funct3, op_a, op_b, rd_in and sets busy. Next state: FIX if special case, else CALC (count=0).
//     Operands are not sampled again; later changes to op_a/op_b are ignored.
//   Special cases (divide ops only; take no CALC cycles):
//     op_b==0: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> op_a.
//     DIV/REM with op_a==32'h8000_0000 and op_b==32'hFFFF_FFFF: DIV -> 32'h8000_0000; REM -> 0.
//   CALC: exactly 32 cycles, then FIX.
//     Divide: restoring division on magnitudes (magnitude taken for the signed operands of DIV/REM only).
//     Multiply: shift-add on magnitudes into a 64-bit product register. op_a is signed for MUL/MULH/MULHSU;
//       op_b is signed for MUL/MULH.
//   FIX (1 cycle): negate as required, then select the result.
//     Product is negated if the operand signs differ.
//     Quotient is negated if the signs differ (DIV).
//     Remainder takes the dividend's sign (REM).
//     MUL selects product[31:0]; MULH* select product[63:32].
//   DONE (1 cycle): done=rd_we=1; result and rd_out valid. Next state IDLE with busy=0.
//   Latency:
//     Normal op: done is high in the cycle after the 34th edge, counting the edge that sampled start as edge 1.
//     Special case: done is high after the 2nd edge.
//     Back-to-back: a new start is accepted in the first IDLE cycle after DONE.
//   start while busy: ignored and not queued.
//   rst asserted mid-operation: abort to IDLE on that edge; done is never pulsed for the aborted op; result=0.
//   start and rst in the same cycle: rst wins.
//   Arithmetic: all results are mod 2^32. No exceptions or flags are produced.
// TESTING
//   MUL 7*(-3): op_a=7, op_b=32'hFFFF_FFFD, funct3=000 -> result=32'hFFFF_FFEB, done after edge 34, rd_we=1, rd_out=rd_in.
//   MULH/MULHSU/MULHU, op_a=op_b=32'h8000_0000:
//     MULH -> 32'h4000_0000; MULHU -> 32'h4000_0000; MULHSU -> 32'hC000_0000.
//   DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//   Special cases, each with done after edge 2:
//     DIVU x/0 -> 32'hFFFF_FFFF; REM 5/0 -> 5; DIV 32'h8000_0000 / -1 -> 32'h8000_0000; REM of the same -> 0.
//   start pulsed at cycles 5 and 20 with different operands -> only the first op completes; busy stays 1 throughout.
//   Back-to-back start in the IDLE cycle after DONE -> accepted.
//   rst at CALC cycle 10 -> next cycle busy=0, result=0, no done pulse.
//   A fresh start afterwards computes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, radix-2, one operation in flight.
// Signed operands are reduced to magnitudes; signs are reapplied in FIX.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            rd_we,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [2:0]      fn_q;
    logic [XLEN-1:0] a_mag_q, b_mag_q;
    logic [XLEN-1:0] hi_q, lo_q, spec_q;
    logic            special_q, neg_q, a_neg_q;

    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic            div0, ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, spec_val;

    always_comb begin
        is_div   = funct3[2];
        a_sgn    = is_div ? ~funct3[0] : (funct3 != 3'b011);
        b_sgn    = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_sgn & op_a[XLEN-1];
        b_neg    = b_sgn & op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div0     = is_div && (op_b == '0);
        ovf      = is_div && !funct3[0]
                   && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (op_b == '1);
        special  = div0 | ovf;
        spec_val = '1;
        if (div0)
            spec_val = funct3[1] ? op_a : '1;
        else if (ovf)
            spec_val = funct3[1] ? '0 : op_a;
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    logic [XLEN:0]   sum, shifted;
    logic            ge;
    logic [XLEN-1:0] hi_step, lo_step;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        ge      = shifted >= {1'b0, b_mag_q};
        if (fn_q[2]) begin
            hi_step = ge ? shifted[XLEN-1:0] - b_mag_q
                         : shifted[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], ge};
        end else begin
            hi_step = sum[XLEN:1];
            lo_step = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod    = {hi_q, lo_q};
        prod_s  = neg_q ? -prod : prod;
        fix_val = spec_q;
        if (!special_q) begin
            if (!fn_q[2])
                fix_val = (fn_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                               : prod_s[2*XLEN-1:XLEN];
            else if (!fn_q[1])
                fix_val = neg_q ? -lo_q : lo_q;
            else
                fix_val = a_neg_q ? -hi_q : hi_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = special ? FIX : CALC;
            CALC: if (count_q == CW'(XLEN-1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            fn_q      <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            spec_q    <= '0;
            special_q <= 1'b0;
            neg_q     <= 1'b0;
            a_neg_q   <= 1'b0;
            rd_out    <= '0;
            result    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    fn_q      <= funct3;
                    a_mag_q   <= a_mag;
                    b_mag_q   <= b_mag;
                    neg_q     <= a_neg ^ b_neg;
                    a_neg_q   <= a_neg;
                    special_q <= special;
                    spec_q    <= spec_val;
                    rd_out    <= rd_in;
                    count_q   <= '0;
                    hi_q      <= '0;
                    lo_q      <= is_div ? a_mag : b_mag;
                end
                CALC: begin
                    hi_q    <= hi_step;
                    lo_q    <= lo_step;
                    count_q <= count_q + 1'b1;
                end
                FIX:  result <= fix_val;
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign rd_we = done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an
// arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  rd_in, rd_out;
    logic        busy, done, rd_we;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .rd_we  (rd_we),
        .rd_out (rd_out),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f3,
                                      input logic [31:0] a, b);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a, b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f3,
                         input logic [31:0] a, b,
                         input logic [4:0] rd);
        int n;
        int exp_lat;
        logic [31:0] exp;
        exp     = model(f3, a, b);
        exp_lat = is_special(f3, a, b) ? 2 : 34;
        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);
        check_eq("res_hold", result, last_res);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
        check_eq("busy", busy, 1);
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_eq($sformatf("lat f3=%0d", f3), n, exp_lat);
        check_eq($sformatf("res f3=%0d a=%h b=%h", f3, a, b),
                 result, exp);
        check_eq("rd_out", rd_out, rd);
        check_eq("rd_we", rd_we, 1);
        last_res = exp;
    endtask

    logic [2:0]  d_f3 [16];
    logic [31:0] d_a  [16];
    logic [31:0] d_b  [16];

    initial begin
        int n;
        bit bad;
        logic [31:0] exp;
        logic [2:0]  f3;
        logic [31:0] a, b;

        d_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                 3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd4, 3'd7, 3'd1};
        d_a  = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                 -32'sd7, -32'sd7, 32'd100, 32'd100,
                 32'h1234_5678, 32'd5, 32'h8000_0000, 32'h8000_0000,
                 32'hFFFF_FFFF, 32'd9, 32'd9, 32'hFFFF_FFFF};
        d_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000,
                 32'h8000_0000, 32'd2, 32'd2, 32'd7, 32'd7,
                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF};

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_we", rd_we, 0);
        check_eq("rst_rd", rd_out, 0);
        check_eq("rst_res", result, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            do_op(d_f3[i], d_a[i], d_b[i], 5'(i + 3));

        // second start mid-operation must be dropped
        exp = model(3'd5, 32'd1000, 32'd7);
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        op_a   = 32'd1000;
        op_b   = 32'd7;
        rd_in  = 5'd9;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        bad   = 1'b0;
        while (!done && n < 100) begin
            if (!busy) bad = 1'b1;
            start = (n == 15);
            funct3 = 3'd0;
            op_a   = 32'd3;
            op_b   = 32'd4;
            rd_in  = 5'd20;
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("ign_busy", bad, 0);
        check_eq("ign_lat", n, 34);
        check_eq("ign_res", result, exp);
        check_eq("ign_rd", rd_out, 5'd9);
        last_res = exp;

        // reset aborts an operation in CALC
        @(negedge clk);
        check_eq("pre_abort_idle", busy, 0);
        start  = 1'b1;
        funct3 = 3'd0;
        op_a   = 32'd11;
        op_b   = 32'd13;
        rd_in  = 5'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_res", result, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_rd", rd_out, 0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) bad = 1'b1;
        end
        check_eq("abort_nodone", bad, 0);
        last_res = '0;

        // reset wins over a simultaneous start
        rst    = 1'b1;
        start  = 1'b1;
        funct3 = 3'd4;
        op_a   = 32'd1;
        op_b   = 32'd0;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_start_busy", busy, 0);

        do_op(3'd0, 32'd6, 32'd7, 5'd1);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op(f3, a, b, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
